// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel debouncer with 2-FF synchronisers, a shared sample
// prescaler and per-channel stability counters producing levels and edge strobes.
module multi_debouncer #(
  parameter int                  CHANNELS      = 4,
  parameter int                  STABLE_CYCLES = 4,
  parameter int                  SAMPLE_DIV    = 1,
  parameter logic [CHANNELS-1:0] RESET_LEVEL   = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0] sync1_r;
  logic [CHANNELS-1:0] sync2_r;
  logic [PW-1:0]       presc_r;
  logic [PW-1:0]       presc_s;
  logic                tick_s;
  logic [CW-1:0]       cnt_r [CHANNELS];
  logic [CW-1:0]       cnt_s [CHANNELS];
  logic [CHANNELS-1:0] out_r;
  logic [CHANNELS-1:0] out_s;
  logic [CHANNELS-1:0] rise_r;
  logic [CHANNELS-1:0] rise_s;
  logic [CHANNELS-1:0] fall_r;
  logic [CHANNELS-1:0] fall_s;
  logic                any_r;

  assign out        = out_r;
  assign rise       = rise_r;
  assign fall       = fall_r;
  assign any_change = any_r;

  // Sample prescaler: tick on the last count of every SAMPLE_DIV-cycle window.
  always_comb begin
    presc_s = presc_r;
    tick_s  = 1'b1;
    if (SAMPLE_DIV > 1) begin
      tick_s = (presc_r == PRESC_LAST);
      if (tick_s) begin
        presc_s = '0;
      end else begin
        presc_s = presc_r + PW'(1);
      end
    end else begin
      presc_s = '0;
    end
  end

  // Per-channel stability counting and commit decision on each sample tick.
  always_comb begin
    out_s  = out_r;
    rise_s = '0;
    fall_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_s[i] = cnt_r[i];
      if (!tick_s) begin
        cnt_s[i] = cnt_r[i];
      end else if (sync2_r[i] == out_r[i]) begin
        cnt_s[i] = '0;
      end else if (cnt_r[i] == CNT_LAST) begin
        // commit: the new level has been seen on STABLE_CYCLES consecutive ticks
        out_s[i]  = sync2_r[i];
        cnt_s[i]  = '0;
        rise_s[i] = sync2_r[i];
        fall_s[i] = ~sync2_r[i];
      end else begin
        cnt_s[i] = cnt_r[i] + CW'(1);
      end
    end
  end

  // State registers: synchronisers, prescaler, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= RESET_LEVEL;
      sync2_r <= RESET_LEVEL;
      presc_r <= '0;
      out_r   <= RESET_LEVEL;
      rise_r  <= '0;
      fall_r  <= '0;
      any_r   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= in;
      sync2_r <= sync1_r;
      presc_r <= presc_s;
      out_r   <= out_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      any_r   <= |(rise_s | fall_s);
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
    end
  end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised N-channel debouncer; successor to the single-input push-button debouncer.
- Each channel has a 2-FF synchroniser, its own stability counter and a shared sample prescaler.
- Outputs per channel: a debounced level plus one-cycle rise and fall strobes.
- Sits between raw board inputs (buttons, switches) and the CPU/IO logic, which uses the strobes as clean single-cycle events.

Parameters:
- CHANNELS, 4: number of independent inputs; must be ≥1.
- STABLE_CYCLES, 4: consecutive differing sample ticks required before the output changes; must be ≥1.
- SAMPLE_DIV, 1: a sample tick occurs every SAMPLE_DIV clk cycles; must be ≥1; 1 means every cycle.
- RESET_LEVEL, {CHANNELS{1'b0}}: per-channel reset value of the synchronisers and debounced outputs.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in, input, CHANNELS: raw asynchronous inputs.
- out, output, CHANNELS: debounced levels (registered).
- rise, output, CHANNELS: one-clk pulse when out[i] goes 0→1.
- fall, output, CHANNELS: one-clk pulse when out[i] goes 1→0.
- any_change, output, 1: OR of rise|fall, same cycle as the strobes.

Behaviour:
- Reset (rst_n=0, asynchronous assert):
  - sync1 = sync2 = out = RESET_LEVEL.
  - All counters = 0, prescaler = 0.
  - rise = fall = any_change = 0.
- Reset deassertion takes effect at the next rising clk edge.
- Synchroniser: sync1 <= in; sync2 <= sync1 every clk edge, independent of the tick. Only sync2 feeds the debounce logic.
- Prescaler:
  - Width $clog2(SAMPLE_DIV), minimum 1 bit.
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick = (prescaler == SAMPLE_DIV-1).
  - When SAMPLE_DIV == 1, tick is constantly 1.
- Per-channel counter:
  - Width $clog2(STABLE_CYCLES+1).
  - Saturation is impossible because the counter clears on commit.
- Per channel, on each clk edge where tick = 1:
  - If sync2[i] == out[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_CYCLES-1: out[i] <= sync2[i], cnt[i] <= 0, and rise[i] or fall[i] <= 1 according to the new value.
  - Else: cnt[i] <= cnt[i]+1.
- On edges with tick = 0: counters and out hold.
- rise, fall and any_change are registered and high for exactly one clk cycle. They are 0 in every cycle without a commit.
- Latency with SAMPLE_DIV=1:
  - Take an input change first captured at edge k and held.
  - out changes at edge k+1+STABLE_CYCLES, i.e. STABLE_CYCLES+2 edges counting k.
  - rise/fall are asserted in the same cycle as the new out value.
- Glitch rejection: any sample with sync2 == out before the commit clears the count. Pulses shorter than STABLE_CYCLES ticks at sync2 never propagate.
- Channels are fully independent. Simultaneous commits on several channels assert several rise/fall bits in the same cycle, and any_change = 1 once.
- Reset mid-count: counters are cleared and out returns to RESET_LEVEL. No strobe is generated for the reset-induced level change.
- If in[i] reverts in the same tick that would otherwise commit: the comparison uses sync2, so a commit happens only if sync2 still differs at that tick. Otherwise the counter clears and there is no strobe.

Test Plan:
1. Reset and hold:
   - Stimulus: defaults, RESET_LEVEL=0, rst_n low 3 cycles with in=4'hF.
   - Required: out=0, rise=fall=any_change=0 throughout reset.
   - After release with in held at 4'hF: out=4'hF at the 6th edge after release, rise=4'hF and any_change=1 for exactly one cycle.
2. Glitch rejection:
   - Stimulus: in[0] high for 3 clk cycles then low, STABLE_CYCLES=4.
   - Required: out[0] stays 0 and rise[0] never asserts.
   - A 4-cycle pulse instead: rise[0] fires once, then fall[0] fires once 4 ticks after sync2 returns low.
3. Bounce train:
   - Stimulus: in[1] toggles 1,0,1,1,0,1,1,1,1 (one value per cycle).
   - Required: a single rise[1] only after the final 4-cycle-stable run; no fall[1].
4. Prescaler:
   - Stimulus: SAMPLE_DIV=3, STABLE_CYCLES=2, in[2] held high.
   - Required: out[2] commits on the 2nd consecutive tick (ticks every 3rd edge); rise[2] is exactly one clk wide.
5. Mid-count reset:
   - Stimulus: in[3] high; assert rst_n asynchronously between edges when cnt[3]=2.
   - Required: out[3]=0 immediately, no strobe.
   - After release: a full STABLE_CYCLES+2 edges elapse before out[3]=1.
6. Simultaneous channels:
   - Stimulus: in 4'b0000→4'b0101 in the same cycle.
   - Required: rise=4'b0101 in one cycle, any_change=1 for one cycle, fall=0.
